rr_arbiter_param: RTL

Parametrised round-robin arbiter that grants one of N requesters access to a shared resource, such as the NN calculator's MAC/memory port. It generalises the earlier fixed five-requester arbiter with these additions:
- per-grant hold/lock across multi-cycle transfers via a release handshake;
- an optional maximum-tenure timeout that forces rotation;
- a priority-mask input.
Sits between requesting engines and the shared datapath mux; the registered one-hot grant drives the mux select.

---
 rtl/arb_pkg.sv | 36 +++
 rtl/rr_pick_comb.sv | 27 ++
 rtl/rr_arbiter_param.sv | 130 +++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared arbiter types and helpers: FSM state, one-hot to index, reference round-robin pick.
package arb_pkg;

  typedef enum logic [0:0] {StIdle, StBusy} arb_state_e;

  function automatic logic [4:0] onehot2idx(input logic [31:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

  // Loop-based circular search from ptr; handy as a golden model for rr_pick_comb.
  function automatic logic [31:0] rr_pick(input logic [31:0] eff, input logic [4:0] ptr,
                                          input int unsigned n);
    logic [31:0]  win;
    logic         found;
    int unsigned  idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (!found && eff[idx[4:0]]) begin
          win[idx[4:0]] = 1'b1;
          found         = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Circular priority encoder: one-hot first set bit of eff searching upward from ptr.
module rr_pick_comb #(
  parameter int unsigned N    = 5,
  parameter int unsigned IDXW = $clog2(N)
) (
  input  logic [N-1:0]    eff,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    winner,
  output logic            any
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] rot;
  logic [N-1:0]   low;
  logic [N-1:0]   first;

  // Rotate right by ptr, isolate the lowest set bit, then rotate back left by ptr.
  always_comb begin
    dbl    = {eff, eff} >> ptr;
    low    = dbl[N-1:0];
    first  = low & ((~low) + N'(1));
    rot    = {first, first} << ptr;
    winner = rot[2*N-1:N];
    any    = |eff;
  end

endmodule

// File: rtl/rr_arbiter_param.sv
// Parametrised round-robin arbiter with lock/hold, tenure timeout and eligibility mask.
module rr_arbiter_param
  import arb_pkg::*;
#(
  parameter int unsigned N        = 5,
  parameter int unsigned MAX_HOLD = 16,
  localparam int unsigned IDXW    = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    lock,
  input  logic [N-1:0]    mask,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid,
  output logic            timeout
);

  localparam int unsigned   HCW     = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HoldMax = HCW'(MAX_HOLD);

  arb_state_e      state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] idx_q;
  logic            valid_q;
  logic            timeout_q, timeout_d;
  logic [HCW-1:0]  hold_q, hold_d, hold_inc;

  logic [N-1:0]    eff;
  logic [N-1:0]    pick;
  logic            pick_any;
  logic [4:0]      pick_idx5, grant_idx5;
  logic [IDXW-1:0] ptr_next;
  logic            owner_live, owner_lock, others, expired, rearb;

  assign eff = req & mask;

  rr_pick_comb #(
    .N    (N),
    .IDXW (IDXW)
  ) u_pick (
    .eff    (eff),
    .ptr    (ptr_q),
    .winner (pick),
    .any    (pick_any)
  );

  always_comb begin
    pick_idx5 = onehot2idx(32'(pick));
    ptr_next  = (pick_idx5[IDXW-1:0] == IDXW'(N - 1)) ? '0 : pick_idx5[IDXW-1:0] + 1'b1;
    if (MAX_HOLD == 0 || hold_q == HoldMax) hold_inc = hold_q;
    else                                    hold_inc = hold_q + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    timeout_d  = 1'b0;
    rearb      = 1'b0;
    owner_live = |(eff & grant_q);
    owner_lock = |(lock & grant_q);
    others     = |(eff & ~grant_q);
    expired    = (MAX_HOLD != 0) && (hold_q == HoldMax);

    unique case (state_q)
      StIdle: rearb = 1'b1;
      StBusy: begin
        if (!owner_live) begin
          rearb = 1'b1;
        end else if (owner_lock) begin
          if (expired && others) begin
            // ptr already sits just past the owner, so the pick lands on someone else.
            rearb     = 1'b1;
            timeout_d = 1'b1;
          end else begin
            hold_d = hold_inc;
          end
        end else begin
          rearb = 1'b1;
        end
      end
      default: ;
    endcase

    if (rearb) begin
      if (pick_any) begin
        grant_d = pick;
        ptr_d   = ptr_next;
        state_d = StBusy;
        hold_d  = (pick == grant_q) ? hold_inc : HCW'(1);
      end else begin
        grant_d = '0;
        state_d = StIdle;
        hold_d  = '0;
      end
    end

    grant_idx5 = onehot2idx(32'(grant_d));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      ptr_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      idx_q     <= grant_idx5[IDXW-1:0];
      valid_q   <= |grant_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;
  assign timeout     = timeout_q;

endmodule
